// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_monitor
// Purpose  : Passive I2C decoder. Synchronises and deglitches SCL/SDA, then
//            reports START/rSTART/STOP, bytes with ACK, and frame errors.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_start,
  output logic       o_rstart,
  output logic       o_stop,
  output logic       o_byte_vld,
  output logic [7:0] o_byte,
  output logic       o_ack,
  output logic [2:0] o_byte_idx,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam int                 c_cnt_w   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILT_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] filt_prev_q;

  assign w_raw = {i_sda, i_scl};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_q;
      logic [c_cnt_w-1:0]     cnt_q;
      logic                   filt_q;
      logic                   w_synced;

      assign w_synced = sync_q[SYNC_STAGES-1];

      // Filtered level only follows after FILT_LEN consecutive differing clocks.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          sync_q <= '1;
          cnt_q  <= '0;
          filt_q <= 1'b1;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], w_raw[gi]};
          if (w_synced == filt_q) begin
            cnt_q <= '0;
          end else if (cnt_q == c_cnt_max) begin
            filt_q <= w_synced;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + c_cnt_w'(1);
          end
        end
      end

      assign w_filt[gi] = filt_q;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) filt_prev_q <= 2'b11;
    else       filt_prev_q <= w_filt;
  end

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_hold_hi;
  logic w_start_cond;
  logic w_stop_cond;

  assign w_scl         = w_filt[0];
  assign w_sda         = w_filt[1];
  assign w_scl_rise    = w_scl & ~filt_prev_q[0];
  assign w_scl_hold_hi = w_scl &  filt_prev_q[0];
  assign w_start_cond  = w_scl_hold_hi & ~w_sda &  filt_prev_q[1];
  assign w_stop_cond   = w_scl_hold_hi &  w_sda & ~filt_prev_q[1];

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       ack_q, ack_d;
  logic [2:0] idx_q, idx_d;
  logic       start_q, start_d;
  logic       rstart_q, rstart_d;
  logic       stop_q, stop_d;
  logic       vld_q, vld_d;
  logic       ferr_q, ferr_d;
  logic       w_partial;

  // The SCL rise that sets up a STOP or repeated START is itself counted as a
  // bit, so only more than one pending bit means a byte was cut short.
  assign w_partial = (bit_cnt_q > 4'd1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    ack_d     = ack_q;
    idx_d     = idx_q;
    start_d   = 1'b0;
    rstart_d  = 1'b0;
    stop_d    = 1'b0;
    vld_d     = 1'b0;
    ferr_d    = 1'b0;

    if (vld_q && (idx_q != 3'd7)) idx_d = idx_q + 3'd1;

    if (w_start_cond) begin
      start_d   = (state_q == ST_IDLE);
      rstart_d  = (state_q == ST_BUSY);
      ferr_d    = w_partial;
      bit_cnt_d = 4'd0;
      idx_d     = 3'd0;
      state_d   = ST_BUSY;
    end else if (w_stop_cond) begin
      stop_d    = 1'b1;
      ferr_d    = w_partial;
      bit_cnt_d = 4'd0;
      state_d   = ST_IDLE;
    end else if (w_scl_rise && (state_q == ST_BUSY)) begin
      if (bit_cnt_q == 4'd8) begin
        byte_d    = shift_q;
        ack_d     = w_sda;
        vld_d     = 1'b1;
        bit_cnt_d = 4'd0;
      end else begin
        shift_d   = {shift_q[6:0], w_sda};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      byte_q    <= 8'd0;
      ack_q     <= 1'b0;
      idx_q     <= 3'd0;
      start_q   <= 1'b0;
      rstart_q  <= 1'b0;
      stop_q    <= 1'b0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      ack_q     <= ack_d;
      idx_q     <= idx_d;
      start_q   <= start_d;
      rstart_q  <= rstart_d;
      stop_q    <= stop_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_start     = start_q;
  assign o_rstart    = rstart_q;
  assign o_stop      = stop_q;
  assign o_byte_vld  = vld_q;
  assign o_byte      = byte_q;
  assign o_ack       = ack_q;
  assign o_byte_idx  = idx_q;
  assign o_busy      = (state_q == ST_BUSY);
  assign o_frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_monitor
// Purpose  : Directed bus transactions against a transaction-level model of
//            the I2C monitor, checked every cycle plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 3;
  localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;
  localparam int MAXC        = 16384;
  localparam int H           = 20;
  localparam int Q           = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       o_start, o_rstart, o_stop, o_byte_vld, o_ack, o_busy, o_frame_err;
  logic [7:0] o_byte;
  logic [2:0] o_byte_idx;

  i2c_bus_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_scl       (scl),
    .i_sda       (sda),
    .o_start     (o_start),
    .o_rstart    (o_rstart),
    .o_stop      (o_stop),
    .o_byte_vld  (o_byte_vld),
    .o_byte      (o_byte),
    .o_ack       (o_ack),
    .o_byte_idx  (o_byte_idx),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected events, indexed by the cycle on which the pulse must appear.
  bit         e_start [MAXC];
  bit         e_rstart[MAXC];
  bit         e_stop  [MAXC];
  bit         e_ferr  [MAXC];
  bit         e_vld   [MAXC];
  bit         e_bset  [MAXC];
  bit         e_bclr  [MAXC];
  logic [7:0] e_byte  [MAXC];
  bit         e_ack   [MAXC];
  logic [2:0] e_idx   [MAXC];

  bit         m_busy  = 1'b0;
  int         m_bits  = 0;
  logic [7:0] m_shift = 8'd0;
  int         m_idx   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       a;
    logic [2:0] i;
  } obs_t;

  obs_t obs_q[$];
  int   n_start = 0, n_rstart = 0, n_stop = 0, n_ferr = 0;
  int   s_start = 0, s_rstart = 0, s_stop = 0, s_ferr = 0;
  int   last_stop_cyc = -1, last_ferr_cyc = -2;
  bit   armed    = 1'b0;
  bit   exp_busy = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic obs_t obs_at(input int i);
    obs_t o;
    o = '0;
    if (i < obs_q.size()) o = obs_q[i];
    return o;
  endfunction

  // ---------------------------------------------------------------- model
  function automatic void sched_start(input int n);
    int e;
    e = n + LAT;
    if (e < MAXC) begin
      if (m_busy) e_rstart[e] = 1'b1;
      else        e_start[e]  = 1'b1;
      if (m_bits > 1) e_ferr[e] = 1'b1;
      e_bset[e] = 1'b1;
    end
    m_bits = 0;
    m_idx  = 0;
    m_busy = 1'b1;
  endfunction

  function automatic void sched_stop(input int n);
    int e;
    e = n + LAT;
    if (e < MAXC) begin
      e_stop[e] = 1'b1;
      if (m_bits > 1) e_ferr[e] = 1'b1;
      e_bclr[e] = 1'b1;
    end
    m_bits = 0;
    m_busy = 1'b0;
  endfunction

  function automatic void sched_rise(input int n, input logic b);
    int e;
    e = n + LAT;
    if (!m_busy) return;
    if (m_bits == 8) begin
      if (e < MAXC) begin
        e_vld[e]  = 1'b1;
        e_byte[e] = m_shift;
        e_ack[e]  = b;
        e_idx[e]  = 3'(m_idx);
      end
      if (m_idx < 7) m_idx++;
      m_bits = 0;
    end else begin
      m_shift = {m_shift[6:0], b};
      m_bits++;
    end
  endfunction

  // --------------------------------------------------------- bus drivers
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda = 1'b0; sched_start(cyc); tick(H);
    scl = 1'b0; tick(H);
  endtask

  task automatic bus_bit(input logic b);
    sda = b;    tick(Q);
    scl = 1'b1; sched_rise(cyc, b); tick(H);
    scl = 1'b0; tick(Q);
  endtask

  task automatic bus_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    bus_bit(ack);
  endtask

  task automatic bus_stop();
    sda = 1'b0; tick(Q);
    scl = 1'b1; sched_rise(cyc, 1'b0); tick(H);
    sda = 1'b1; sched_stop(cyc); tick(H);
  endtask

  task automatic bus_rstart();
    sda = 1'b1; tick(Q);
    scl = 1'b1; sched_rise(cyc, 1'b1); tick(H);
    sda = 1'b0; sched_start(cyc); tick(H);
    scl = 1'b0; tick(Q);
  endtask

  task automatic snap();
    obs_q.delete();
    s_start  = n_start;
    s_rstart = n_rstart;
    s_stop   = n_stop;
    s_ferr   = n_ferr;
  endtask

  // ------------------------------------------------------ compare process
  always @(negedge clk) begin
    bit eb;
    if (armed) begin
      if (rst) begin
        chk("reset_outputs", int'({o_start, o_rstart, o_stop, o_byte_vld, o_byte, o_ack,
                                   o_byte_idx, o_busy, o_frame_err}), 0);
        exp_busy <= 1'b0;
      end else if (cyc < MAXC) begin
        eb = exp_busy;
        if (e_bset[cyc]) eb = 1'b1;
        if (e_bclr[cyc]) eb = 1'b0;
        exp_busy <= eb;
        chk("start",     int'(o_start),     int'(e_start[cyc]));
        chk("rstart",    int'(o_rstart),    int'(e_rstart[cyc]));
        chk("stop",      int'(o_stop),      int'(e_stop[cyc]));
        chk("frame_err", int'(o_frame_err), int'(e_ferr[cyc]));
        chk("byte_vld",  int'(o_byte_vld),  int'(e_vld[cyc]));
        chk("busy",      int'(o_busy),      int'(eb));
        if (e_vld[cyc]) begin
          chk("byte",     int'(o_byte),     int'(e_byte[cyc]));
          chk("ack",      int'(o_ack),      int'(e_ack[cyc]));
          chk("byte_idx", int'(o_byte_idx), int'(e_idx[cyc]));
        end
        if (o_start)     n_start++;
        if (o_rstart)    n_rstart++;
        if (o_stop)      begin n_stop++; last_stop_cyc = cyc; end
        if (o_frame_err) begin n_ferr++; last_ferr_cyc = cyc; end
        if (o_byte_vld)  obs_q.push_back({o_byte, o_ack, o_byte_idx});
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [7:0] d;
    logic [2:0] idx_tbl [9];
    logic       rst_bits [5];
    logic       orphan [4];
    idx_tbl  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    rst_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    orphan   = '{1'b0, 1'b1, 1'b1, 1'b0};

    tick(2);
    armed = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);

    // Two bytes, ACK then NACK, plain STOP.
    snap();
    bus_start();
    bus_byte(8'hA4, 1'b0);
    bus_byte(8'h3C, 1'b1);
    bus_stop();
    tick(LAT + 4);
    chk("t1_nbytes", obs_q.size(), 2);
    chk("t1_b0",     int'(obs_at(0).b), 'hA4);
    chk("t1_a0",     int'(obs_at(0).a), 0);
    chk("t1_i0",     int'(obs_at(0).i), 0);
    chk("t1_b1",     int'(obs_at(1).b), 'h3C);
    chk("t1_a1",     int'(obs_at(1).a), 1);
    chk("t1_i1",     int'(obs_at(1).i), 1);
    chk("t1_starts", n_start - s_start, 1);
    chk("t1_stops",  n_stop - s_stop, 1);
    chk("t1_ferrs",  n_ferr - s_ferr, 0);

    // Repeated START restarts the byte index.
    snap();
    bus_start();
    bus_byte(8'hA4, 1'b0);
    bus_rstart();
    bus_byte(8'hA5, 1'b0);
    bus_byte(8'h7E, 1'b1);
    bus_stop();
    tick(LAT + 4);
    chk("t2_starts",  n_start - s_start, 1);
    chk("t2_rstarts", n_rstart - s_rstart, 1);
    chk("t2_nbytes",  obs_q.size(), 3);
    chk("t2_i0",      int'(obs_at(0).i), 0);
    chk("t2_b1",      int'(obs_at(1).b), 'hA5);
    chk("t2_i1",      int'(obs_at(1).i), 0);
    chk("t2_b2",      int'(obs_at(2).b), 'h7E);
    chk("t2_i2",      int'(obs_at(2).i), 1);
    chk("t2_ferrs",   n_ferr - s_ferr, 0);

    // SDA glitches with SCL high: 2 clocks suppressed, 3 clocks accepted.
    snap();
    sda = 1'b0; tick(2);
    sda = 1'b1; tick(30);
    chk("glitch2_starts", n_start - s_start, 0);
    chk("glitch2_stops",  n_stop - s_stop, 0);
    snap();
    sda = 1'b0; sched_start(cyc); tick(3);
    sda = 1'b1; sched_stop(cyc);  tick(30);
    chk("glitch3_starts", n_start - s_start, 1);
    chk("glitch3_stops",  n_stop - s_stop, 1);

    // STOP in the middle of a byte.
    snap();
    bus_start();
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
    bus_stop();
    tick(LAT + 4);
    chk("t4_ferrs",      n_ferr - s_ferr, 1);
    chk("t4_stops",      n_stop - s_stop, 1);
    chk("t4_nbytes",     obs_q.size(), 0);
    chk("t4_same_cycle", last_ferr_cyc, last_stop_cyc);
    chk("t4_busy_after", int'(o_busy), 0);

    // Nine bytes: index saturates at 7.
    snap();
    bus_start();
    for (int i = 0; i < 9; i++) begin
      d = 8'h10 + 8'(i);
      bus_byte(d, 1'b0);
    end
    bus_stop();
    tick(LAT + 4);
    chk("t5_nbytes", obs_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk("t5_idx",  int'(obs_at(i).i), int'(idx_tbl[i]));
      chk("t5_byte", int'(obs_at(i).b), 'h10 + i);
    end

    // Reset mid-byte, orphan bits ignored until the next START.
    snap();
    bus_start();
    for (int i = 0; i < 5; i++) bus_bit(rst_bits[i]);
    rst    = 1'b1;
    m_busy = 1'b0;
    m_bits = 0;
    m_idx  = 0;
    tick(3);
    rst = 1'b0;
    tick(12);
    snap();
    for (int i = 0; i < 4; i++) bus_bit(orphan[i]);
    chk("t6_orphan_bytes",  obs_q.size(), 0);
    chk("t6_orphan_events", (n_start - s_start) + (n_stop - s_stop) + (n_rstart - s_rstart), 0);
    sda = 1'b1; tick(Q);
    scl = 1'b1; tick(H);
    bus_start();
    bus_byte(8'h55, 1'b0);
    bus_stop();
    tick(LAT + 4);
    chk("t6_starts", n_start - s_start, 1);
    chk("t6_nbytes", obs_q.size(), 1);
    chk("t6_b0",     int'(obs_at(0).b), 'h55);
    chk("t6_i0",     int'(obs_at(0).i), 0);

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
